// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a Wishbone B4 pipelined responder.
// Every accepted request gets an ack or err exactly one clock later; there are no wait states.
// The 64-bit mtime advances once every PRESCALE+1 clocks while CTRL.EN is set.
// A read of MTIME_LO snapshots the upper half of mtime, so a LO-then-HI read pair is atomic.
module wb_mtimer #(
    parameter logic [31:0] PRESCALE_RST = 32'd99,
    parameter logic        CTRL_EN_RST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic        wb_stall,
    output logic        wb_ack,
    output logic        wb_err,
    output logic [31:0] wb_dat_o,
    output logic        irq_timer
);

    localparam logic [2:0] OffMtimeLo    = 3'd0;
    localparam logic [2:0] OffMtimeHi    = 3'd1;
    localparam logic [2:0] OffMtimecmpLo = 3'd2;
    localparam logic [2:0] OffMtimecmpHi = 3'd3;
    localparam logic [2:0] OffPrescale   = 3'd4;
    localparam logic [2:0] OffCtrl       = 3'd5;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] presc_cnt_q, presc_cnt_d;
    logic [31:0] hi_shadow_q, hi_shadow_d;
    logic        en_q, en_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic        req;
    logic        mapped;
    logic        wr_any;
    logic        rd;
    logic        tick;
    logic [2:0]  off;
    logic [31:0] wmask;
    logic [31:0] rdata;

    // Address bits outside adr[4:2] are deliberately ignored.
    logic unused_adr;
    assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

    assign wb_stall  = 1'b0;
    assign wb_ack    = ack_q;
    assign wb_err    = err_q;
    assign wb_dat_o  = dat_q;
    assign irq_timer = irq_q;

    assign req    = wb_cyc & wb_stb;
    assign off    = wb_adr[4:2];
    assign mapped = (off <= OffCtrl);
    // A write with no byte lanes selected is acked but must not touch any state.
    assign wr_any = req & mapped & wb_we & (|wb_sel);
    assign rd     = req & mapped & ~wb_we;
    assign tick   = en_q & (presc_cnt_q == prescale_q);
    assign wmask  = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};

    // Read data mux; MTIME_HI returns the snapshot taken by the last MTIME_LO read.
    always_comb begin
        rdata = 32'd0;
        case (off)
            OffMtimeLo:    rdata = mtime_q[31:0];
            OffMtimeHi:    rdata = hi_shadow_q;
            OffMtimecmpLo: rdata = mtimecmp_q[31:0];
            OffMtimecmpHi: rdata = mtimecmp_q[63:32];
            OffPrescale:   rdata = prescale_q;
            OffCtrl:       rdata = {31'd0, en_q};
            default:       rdata = 32'd0;
        endcase
    end

    // Next-state for timer registers; a bus write to mtime overrides (and drops) a tick.
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        prescale_d  = prescale_q;
        presc_cnt_d = presc_cnt_q;
        en_d        = en_q;
        hi_shadow_d = hi_shadow_q;

        if (en_q) begin
            presc_cnt_d = tick ? 32'd0 : presc_cnt_q + 32'd1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr_any) begin
            case (off)
                OffMtimeLo: begin
                    mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wmask) | (wb_dat_i & wmask)};
                end
                OffMtimeHi: begin
                    mtime_d = {(mtime_q[63:32] & ~wmask) | (wb_dat_i & wmask), mtime_q[31:0]};
                end
                OffMtimecmpLo: begin
                    mtimecmp_d[31:0] = (mtimecmp_q[31:0] & ~wmask) | (wb_dat_i & wmask);
                end
                OffMtimecmpHi: begin
                    mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (wb_dat_i & wmask);
                end
                OffPrescale: begin
                    prescale_d  = (prescale_q & ~wmask) | (wb_dat_i & wmask);
                    presc_cnt_d = 32'd0;
                end
                OffCtrl: begin
                    if (wb_sel[0]) begin
                        en_d = wb_dat_i[0];
                    end
                    presc_cnt_d = 32'd0;
                end
                default: ;
            endcase
        end

        if (rd && (off == OffMtimeLo)) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    // Bus response and interrupt next-state.
    always_comb begin
        ack_d = req & mapped;
        err_d = req & ~mapped;
        dat_d = rd ? rdata : 32'd0;
        irq_d = (mtime_q >= mtimecmp_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescale_q  <= PRESCALE_RST;
            presc_cnt_q <= 32'd0;
            en_q        <= CTRL_EN_RST;
            hi_shadow_q <= 32'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            prescale_q  <= prescale_d;
            presc_cnt_q <= presc_cnt_d;
            en_q        <= en_d;
            hi_shadow_q <= hi_shadow_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_wb_mtimer.sv
// Self-checking bench for wb_mtimer: expected bus responses are queued as requests are
// issued and popped when the response cycle arrives; timer behaviour is checked inline.
module tb_wb_mtimer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_o;
    logic        irq_timer;

    typedef struct {
        logic        is_err;
        logic [31:0] lo;
        logic [31:0] hi;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    wb_mtimer dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_stall  (wb_stall),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_dat_o  (wb_dat_o),
        .irq_timer (irq_timer)
    );

    // Drive one request (from a negedge), queue its expected response, return at the accept edge.
    task automatic wb_req(input logic we, input logic [2:0] off, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [31:0] lo, input logic [31:0] hi,
                          input string tag);
        exp_t e;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_sel   = sel;
        wb_adr   = {27'd0, off, 2'b11};
        wb_dat_i = dat;
        e.is_err = (off > 3'd5);
        e.lo     = e.is_err ? 32'd0 : lo;
        e.hi     = e.is_err ? 32'd0 : hi;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic wb_release();
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    // Sample the response on the negedge after the accept edge and compare with the queue head.
    task automatic wb_resp();
        exp_t e;
        @(negedge clk);
        n_tests++;
        if (sb.size() == 0) begin
            if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_resp: ack=%b err=%b, want no response", wb_ack, wb_err);
            end
        end else begin
            e = sb.pop_front();
            if (wb_ack !== !e.is_err || wb_err !== e.is_err || $isunknown(wb_dat_o) ||
                wb_dat_o < e.lo || wb_dat_o > e.hi) begin
                n_fail++;
                $display("FAIL %s: ack=%b err=%b dat=%h, want ack=%b err=%b dat in [%h,%h]",
                         e.tag, wb_ack, wb_err, wb_dat_o, !e.is_err, e.is_err, e.lo, e.hi);
            end
            last_rdata = wb_dat_o;
        end
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] lo, input logic [31:0] hi,
                      input string tag);
        wb_req(1'b0, off, 4'hF, 32'd0, lo, hi, tag);
        wb_release();
        wb_resp();
    endtask

    task automatic wr(input logic [2:0] off, input logic [3:0] sel, input logic [31:0] dat,
                      input string tag);
        wb_req(1'b1, off, sel, dat, 32'd0, 32'hFFFF_FFFF, tag);
        wb_release();
        wb_resp();
    endtask

    // Idle cycles: no response may appear without a request.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_tests++;
            if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_resp: ack=%b err=%b, want 0 0", wb_ack, wb_err);
            end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_dat_o !== 32'd0 || irq_timer !== 1'b0 ||
            wb_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b err=%b dat=%h irq=%b stall=%b, want all 0",
                     wb_ack, wb_err, wb_dat_o, irq_timer, wb_stall);
        end
        rd(3'd0, 32'd0, 32'd0, "reset_mtime_lo");
        rd(3'd1, 32'd0, 32'd0, "reset_mtime_hi");
        rd(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset_cmp_hi");
        rd(3'd4, 32'd99, 32'd99, "reset_prescale");
        rd(3'd5, 32'd1, 32'd1, "reset_ctrl");
        idle(2);
    endtask

    task automatic test_prescaler();
        logic [31:0] frozen;
        wr(3'd5, 4'hF, 32'd0, "ps_en_off");
        wr(3'd0, 4'hF, 32'd0, "ps_mtime_lo");
        wr(3'd1, 4'hF, 32'd0, "ps_mtime_hi");
        wr(3'd4, 4'hF, 32'd3, "ps_prescale");
        wr(3'd5, 4'hF, 32'd1, "ps_en_on");
        idle(40);
        // Ticks every 4 clocks from the enable edge.
        rd(3'd0, 32'd9, 32'd11, "ps_count_40clk");
        wr(3'd5, 4'hF, 32'd0, "ps_en_off2");
        rd(3'd0, 32'd9, 32'd11, "ps_frozen_a");
        frozen = last_rdata;
        idle(20);
        rd(3'd0, frozen, frozen, "ps_frozen_b");
    endtask

    task automatic test_shadow();
        wr(3'd5, 4'hF, 32'd0, "sh_en_off");
        wr(3'd0, 4'hF, 32'hFFFF_FFFF, "sh_lo");
        wr(3'd1, 4'hF, 32'd0, "sh_hi");
        wr(3'd4, 4'hF, 32'd0, "sh_prescale0");
        wr(3'd5, 4'hF, 32'd1, "sh_en_on");
        // LO read samples 0_FFFFFFFF while the carry lands; HI must stay on the snapshot.
        rd(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "sh_carry_lo");
        rd(3'd1, 32'd0, 32'd0, "sh_carry_hi");
        idle(1);
        rd(3'd0, 32'd2, 32'd2, "sh_after_lo");
        rd(3'd1, 32'd1, 32'd1, "sh_after_hi");
    endtask

    task automatic test_irq();
        int first;
        wr(3'd5, 4'hF, 32'd0, "irq_en_off");
        wr(3'd0, 4'hF, 32'd0, "irq_mtime_lo");
        wr(3'd1, 4'hF, 32'd0, "irq_mtime_hi");
        wr(3'd3, 4'hF, 32'd0, "irq_cmp_hi");
        wr(3'd2, 4'hF, 32'd20, "irq_cmp_lo");
        wr(3'd4, 4'hF, 32'd0, "irq_prescale0");
        wr(3'd5, 4'hF, 32'd1, "irq_en_on");
        n_tests++;
        if (irq_timer !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_idle_low: irq=%b, want 0", irq_timer);
        end
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (irq_timer === 1'b1 && first == 0) first = i;
        end
        // mtime reaches 20 on edge 20 after enable; irq registers it on edge 21.
        n_tests++;
        if (first !== 21) begin
            n_fail++;
            $display("FAIL irq_rise_edge: rose at edge %0d, want 21", first);
        end
        @(negedge clk);
        wr(3'd3, 4'hF, 32'd1, "irq_clear_cmp_hi");
        n_tests++;
        if (irq_timer !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_hold_1cyc: irq=%b, want 1", irq_timer);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (irq_timer !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall_2cyc: irq=%b, want 0", irq_timer);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // stb stays high across the four requests: one response per clock.
        wb_req(1'b0, 3'd2, 4'hF, 32'd0, 32'd20, 32'd20, "b2b_cmp_lo");
        wb_resp();
        wb_req(1'b0, 3'd3, 4'hF, 32'd0, 32'd1, 32'd1, "b2b_cmp_hi");
        wb_resp();
        wb_req(1'b0, 3'd4, 4'hF, 32'd0, 32'd0, 32'd0, "b2b_prescale");
        wb_resp();
        wb_req(1'b0, 3'd5, 4'hF, 32'd0, 32'd1, 32'd1, "b2b_ctrl");
        wb_release();
        wb_resp();
        idle(1);
        rd(3'd6, 32'd0, 32'd0, "unmapped_rd6");
        rd(3'd7, 32'd0, 32'd0, "unmapped_rd7");
        wr(3'd6, 4'hF, 32'hDEAD_BEEF, "unmapped_wr6");
        rd(3'd4, 32'd0, 32'd0, "unmapped_no_effect");
        idle(2);
    endtask

    task automatic test_sel_and_abort();
        wr(3'd5, 4'h0, 32'd0, "sel0_ctrl_write");
        rd(3'd5, 32'd1, 32'd1, "sel0_en_kept");
        wr(3'd4, 4'hF, 32'h1122_3344, "sel_full");
        wr(3'd4, 4'b0101, 32'hAABB_CCDD, "sel_partial");
        rd(3'd4, 32'h11BB_33DD, 32'h11BB_33DD, "sel_merge");
        // Push state away from reset values, including a live interrupt.
        wr(3'd5, 4'hF, 32'd0, "abort_en_off");
        wr(3'd3, 4'hF, 32'd0, "abort_cmp_hi0");
        idle(2);
        n_tests++;
        if (irq_timer !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_irq_set: irq=%b, want 1", irq_timer);
        end
        // Request presented in the reset cycle: it must never be answered.
        rst      = 1'b1;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = 1'b0;
        wb_sel   = 4'hF;
        wb_adr   = 32'h0000_0014;
        @(posedge clk);
        wb_release();
        @(negedge clk);
        n_tests++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0 || wb_dat_o !== 32'd0 || irq_timer !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_ack: ack=%b err=%b dat=%h irq=%b, want 0 0 0 0",
                     wb_ack, wb_err, wb_dat_o, irq_timer);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        rd(3'd1, 32'd0, 32'd0, "abort_shadow_reset");
        rd(3'd0, 32'd0, 32'd0, "abort_mtime_lo");
        rd(3'd1, 32'd0, 32'd0, "abort_mtime_hi");
        rd(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "abort_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "abort_cmp_hi");
        rd(3'd4, 32'd99, 32'd99, "abort_prescale");
        rd(3'd5, 32'd1, 32'd1, "abort_ctrl");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_sel   = 4'h0;
        wb_adr   = 32'd0;
        wb_dat_i = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_prescaler();
        test_shadow();
        test_irq();
        test_back_to_back();
        test_sel_and_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
